// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI command sequencer.
package spi_reg_pkg;
  localparam int ADDR_W     = 7;
  localparam int CMD_RW_BIT = 7;
  localparam logic [7:0] DEF_STATUS_BYTE = 8'hA5;

  typedef enum logic [2:0] {IDLE, CMD, FETCH, WAITRD, DATA} state_e;
endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-wide register bank bus driven by the SPI command sequencer.
interface spi_reg_ctrl_if;
  import spi_reg_pkg::*;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;

  modport master (output reg_addr, reg_wdata, reg_we, reg_re, input reg_rdata);
  modport slave  (input reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata);
endinterface

// File: rtl/spi_cs_sync.sv
// Two-flop synchronizer for the pad chip select, with frame start/end pulses.
module spi_cs_sync (
  input  logic clk,
  input  logic resetn,
  input  logic cs_n_raw,
  output logic cs_s,
  output logic cs_fall,
  output logic cs_rise
);
  logic meta_q, sync_q, dly_q;

  // All stages reset high so a low CS at reset release reads as a fresh frame start.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= cs_n_raw;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign cs_s    = sync_q;
  assign cs_fall = dly_q & ~sync_q;
  assign cs_rise = ~dly_q & sync_q;
endmodule

// File: rtl/spi_reg_ctrl.sv
// Decodes the first byte of each CS-low frame as a command, then streams bytes
// to/from the register bank with an auto-incrementing address.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS    = 16,
  parameter logic [7:0] STATUS_BYTE = DEF_STATUS_BYTE
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          SPI_CS,
  input  logic          Rx_DV,
  input  logic [7:0]    Rx_Byte,
  output logic [7:0]    Tx_Byte,
  output logic          frame_busy,
  output logic          err,
  spi_reg_ctrl_if.master bus
);
  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NREGS;
  endfunction

  logic cs_s, cs_fall, cs_rise;

  spi_cs_sync u_cs_sync (
    .clk      (clk),
    .resetn   (resetn),
    .cs_n_raw (SPI_CS),
    .cs_s     (cs_s),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise)
  );

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    tx_d       = tx_q;
    reg_addr_d = reg_addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    err_d      = err_q;
    busy_d     = ~cs_s;
    case (state_q)
      IDLE: begin
        tx_d = STATUS_BYTE;
        if (cs_fall) begin
          err_d   = 1'b0;
          state_d = CMD;
        end
      end
      // Read strobe is launched on entry so it is high while the FSM sits in FETCH.
      CMD: if (Rx_DV) begin
        addr_d = Rx_Byte[ADDR_W-1:0];
        rw_d   = Rx_Byte[CMD_RW_BIT];
        if (Rx_Byte[CMD_RW_BIT]) begin
          state_d = DATA;
        end else begin
          state_d    = FETCH;
          re_d       = 1'b1;
          reg_addr_d = Rx_Byte[ADDR_W-1:0];
        end
      end
      FETCH: state_d = WAITRD;
      WAITRD: begin
        if (in_range(addr_q)) begin
          tx_d = bus.reg_rdata;
        end else begin
          tx_d  = 8'h00;
          err_d = 1'b1;
        end
        state_d = DATA;
      end
      DATA: if (Rx_DV) begin
        addr_d = addr_q + 1'b1;
        if (rw_q) begin
          if (in_range(addr_q)) begin
            we_d       = 1'b1;
            reg_addr_d = addr_q;
            wdata_d    = Rx_Byte;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d    = FETCH;
          re_d       = 1'b1;
          reg_addr_d = addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Frame end wins over everything except a write for a byte landing this cycle.
    if (cs_rise) begin
      state_d = IDLE;
      re_d    = 1'b0;
      tx_d    = STATUS_BYTE;
      if (state_q == WAITRD) err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      tx_q       <= STATUS_BYTE;
      reg_addr_q <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      tx_q       <= tx_d;
      reg_addr_q <= reg_addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign Tx_Byte       = tx_q;
  assign frame_busy    = busy_q;
  assign err           = err_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: byte-level SPI emulation, 16x8 register bank and a frame-level model.
module tb_spi_reg_ctrl;
  localparam int HALF = 10;
  localparam int NREG = 16;

  logic       clk = 1'b0, resetn = 1'b0, SPI_CS = 1'b1, Rx_DV = 1'b0;
  logic [7:0] Rx_Byte = 8'h00;
  logic [7:0] Tx_Byte;
  logic       frame_busy, err;

  spi_reg_ctrl_if bus();

  spi_reg_ctrl #(.NUM_REGS(NREG), .STATUS_BYTE(8'hA5)) dut (
    .clk(clk), .resetn(resetn), .SPI_CS(SPI_CS), .Rx_DV(Rx_DV), .Rx_Byte(Rx_Byte),
    .Tx_Byte(Tx_Byte), .frame_busy(frame_busy), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0]  bank [NREG];
  logic [7:0]  mdl_mem [NREG];
  int          n_we = 0, n_re = 0, wr_idx = 0;
  logic [14:0] wr_log [$];
  logic [14:0] exp_wr [$];

  // Register bank: synchronous read, data valid the cycle after reg_re.
  always @(posedge clk) begin
    if (bus.reg_re) begin
      bus.reg_rdata <= (bus.reg_addr < NREG) ? bank[bus.reg_addr[3:0]] : 8'hEE;
      n_re <= n_re + 1;
    end
    if (bus.reg_we) begin
      wr_log.push_back({bus.reg_addr, bus.reg_wdata});
      n_we <= n_we + 1;
      if (bus.reg_addr < NREG) bank[bus.reg_addr[3:0]] <= bus.reg_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame-level reference: addresses advance mod 128 from the command address.
  task automatic model(input logic [7:0] b[4], input int n, output logic [7:0] miso[4],
                       output logic e, output int nre, output int nwe);
    int a0, ai;
    a0 = int'(b[0] & 8'h7F);
    e = 1'b0; nre = 0; nwe = 0;
    for (int k = 0; k < 4; k++) miso[k] = 8'hA5;
    for (int i = 1; i < n; i++) begin
      ai = (a0 + i - 1) % 128;
      if (b[0][7]) begin
        if (ai < NREG) begin
          exp_wr.push_back({7'(ai), b[i]});
          mdl_mem[ai] = b[i];
          nwe++;
        end else e = 1'b1;
      end else begin
        miso[i] = (ai < NREG) ? mdl_mem[ai] : 8'h00;
      end
    end
    if (!b[0][7]) begin
      nre = n;
      for (int k = 0; k < n; k++) if ((a0 + k) % 128 >= NREG) e = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    repeat (16*HALF - 1) @(negedge clk);
    Rx_Byte = v; Rx_DV = 1'b1;
    @(negedge clk);
    Rx_DV = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] b[4], input int n, output logic [7:0] miso[4]);
    for (int k = 0; k < 4; k++) miso[k] = 8'h00;
    @(negedge clk); SPI_CS = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_in_frame", frame_busy, 1);
    chk("err_cleared_at_start", err, 0);
    repeat (2*HALF - 5) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      repeat (HALF) @(negedge clk);
      miso[i] = Tx_Byte;
      repeat (15*HALF - 1) @(negedge clk);
      Rx_Byte = b[i]; Rx_DV = 1'b1;
      @(negedge clk);
      Rx_DV = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    SPI_CS = 1'b1;
    repeat (6) @(negedge clk);
    chk("busy_after_frame", frame_busy, 0);
  endtask

  task automatic chk_writes(input string tag);
    logic [14:0] e;
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      if (wr_idx < wr_log.size()) begin
        chk({tag, "_wr"}, wr_log[wr_idx], e);
        wr_idx++;
      end else begin
        checks++; errors++;
        $display("FAIL %s_wr_missing: got none expected %0h", tag, e);
      end
    end
    if (wr_idx < wr_log.size()) begin
      checks++; errors++;
      $display("FAIL %s_wr_extra: got %0h expected none", tag, wr_log[wr_idx]);
      wr_idx = wr_log.size();
    end
  endtask

  task automatic do_frame(input logic [7:0] b[4], input int n, input string tag);
    logic [7:0] em[4], am[4];
    logic ee;
    int enre, enwe, re0, we0;
    model(b, n, em, ee, enre, enwe);
    re0 = n_re; we0 = n_we;
    run_frame(b, n, am);
    for (int i = 0; i < n; i++) chk($sformatf("%s_miso%0d", tag, i), am[i], em[i]);
    chk({tag, "_err"}, err, ee);
    chk({tag, "_nre"}, n_re - re0, enre);
    chk({tag, "_nwe"}, n_we - we0, enwe);
    chk_writes(tag);
  endtask

  typedef struct {
    logic [7:0] b[4];
    int         n;
    logic [7:0] miso[4];
    logic       e;
    int         nwe;
    int         nre;
  } vec_t;
  vec_t tbl [$];

  task automatic add_vec(input logic [31:0] bytes, input int n, input logic [31:0] miso,
                         input logic e, input int nwe, input int nre);
    vec_t v;
    for (int k = 0; k < 4; k++) begin
      v.b[k]    = bytes[8*(3-k) +: 8];
      v.miso[k] = miso[8*(3-k) +: 8];
    end
    v.n = n; v.e = e; v.nwe = nwe; v.nre = nre;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] fb[4], am[4], em[4];
    logic ee;
    int enre, enwe, re0, we0, a;

    for (int i = 0; i < NREG; i++) begin
      bank[i]    = 8'(i*37 + 5);
      mdl_mem[i] = 8'(i*37 + 5);
    end
    add_vec(32'h835A_0000, 2, 32'hA5A5_0000, 1'b0, 1, 0);
    add_vec(32'h0300_0000, 2, 32'hA55A_0000, 1'b0, 0, 2);
    add_vec(32'h8E0B_1621, 4, 32'hA5A5_A5A5, 1'b1, 2, 0);
    add_vec(32'h8EC1_BE00, 3, 32'hA5A5_A500, 1'b0, 2, 0);
    add_vec(32'h0E00_0000, 4, 32'hA5C1_BE00, 1'b1, 0, 4);

    repeat (3) @(negedge clk);
    chk("rst_tx", Tx_Byte, 8'hA5);
    chk("rst_addr", bus.reg_addr, 0);
    chk("rst_wdata", bus.reg_wdata, 0);
    chk("rst_we", bus.reg_we, 0);
    chk("rst_re", bus.reg_re, 0);
    chk("rst_busy", frame_busy, 0);
    chk("rst_err", err, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    foreach (tbl[t]) begin
      model(tbl[t].b, tbl[t].n, em, ee, enre, enwe);
      re0 = n_re; we0 = n_we;
      run_frame(tbl[t].b, tbl[t].n, am);
      for (int i = 0; i < tbl[t].n; i++) chk($sformatf("vec%0d_miso%0d", t, i), am[i], tbl[t].miso[i]);
      chk($sformatf("vec%0d_err", t), err, tbl[t].e);
      chk($sformatf("vec%0d_nwe", t), n_we - we0, tbl[t].nwe);
      chk($sformatf("vec%0d_nre", t), n_re - re0, tbl[t].nre);
      chk_writes($sformatf("vec%0d", t));
    end
    chk("reg3_after_write", bank[3], 8'h5A);

    // CS raised mid data byte of a write: no strobe, frame ends promptly.
    we0 = n_we;
    @(negedge clk); SPI_CS = 1'b0;
    repeat (2*HALF) @(negedge clk);
    send_byte(8'h85);
    repeat (8*HALF) @(negedge clk);
    SPI_CS = 1'b1;
    repeat (3) @(negedge clk);
    chk("cut_wr_busy_low", frame_busy, 0);
    repeat (HALF) @(negedge clk);
    chk("cut_wr_no_we", n_we - we0, 0);
    chk("cut_wr_reg5", bank[5], mdl_mem[5]);
    // CS raised mid read: Tx falls back to the status byte.
    @(negedge clk); SPI_CS = 1'b0;
    repeat (2*HALF) @(negedge clk);
    send_byte(8'h03);
    repeat (8*HALF) @(negedge clk);
    chk("cut_rd_tx_data", Tx_Byte, mdl_mem[3]);
    SPI_CS = 1'b1;
    repeat (4) @(negedge clk);
    chk("cut_rd_tx_status", Tx_Byte, 8'hA5);
    chk_writes("cut");
    fb = '{8'h81, 8'h77, 8'h00, 8'h00};
    do_frame(fb, 2, "after_cut");
    chk("reg1_after_cut", bank[1], 8'h77);

    // Reset in the middle of a burst read.
    @(negedge clk); SPI_CS = 1'b0;
    repeat (2*HALF) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", Tx_Byte, 8'hA5);
    chk("mid_rst_addr", bus.reg_addr, 0);
    chk("mid_rst_wdata", bus.reg_wdata, 0);
    chk("mid_rst_we", bus.reg_we, 0);
    chk("mid_rst_re", bus.reg_re, 0);
    chk("mid_rst_busy", frame_busy, 0);
    chk("mid_rst_err", err, 0);
    SPI_CS = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    fb = '{8'h03, 8'h00, 8'h00, 8'h00};
    do_frame(fb, 2, "after_rst");

    // Random frames, including addresses near the wrap point.
    for (int r = 0; r < 24; r++) begin
      a = ($urandom % 4 == 0) ? 124 + int'($urandom % 4) : int'($urandom % 20);
      fb[0] = {1'($urandom % 2), 7'(a)};
      for (int k = 1; k < 4; k++) fb[k] = 8'($urandom);
      do_frame(fb, 1 + int'($urandom % 4), $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
